// File: rtl/fifo_wr_ptr_ctrl.sv
// fifo_wr_ptr_ctrl: write-domain pointer/flag controller of the async FIFO (macro FIFO_WR_LEVEL_EN adds wr_level).
// Latency: mem_we/wr_addr combinational; wptr_gray, full, almost_full, overflow, wr_level registered, one clk.
// Backpressure: writes are rejected while the registered full is set; a rejected write sets sticky overflow.
module fifo_wr_ptr_ctrl #(
   parameter int ADDR_SIZE    = 4,
   parameter int AFULL_MARGIN = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 wr_en,
   input  logic [ADDR_SIZE:0]   rptr_sync,
   input  logic                 ovf_clr,
   output logic                 mem_we,
   output logic [ADDR_SIZE-1:0] wr_addr,
   output logic [ADDR_SIZE:0]   wptr_gray,
   output logic                 full,
   output logic                 almost_full,
   output logic                 overflow
`ifdef FIFO_WR_LEVEL_EN
   ,
   output logic [ADDR_SIZE:0]   wr_level
`endif
);

   localparam int                 DEPTH        = 1 << ADDR_SIZE;
   localparam logic [ADDR_SIZE:0] AFULL_THRESH = (ADDR_SIZE+1)'(DEPTH - AFULL_MARGIN);

   logic [ADDR_SIZE:0] wbin;
   logic [ADDR_SIZE:0] wbin_next;
   logic [ADDR_SIZE:0] wgray_next;
   logic [ADDR_SIZE:0] rbin;
   logic [ADDR_SIZE:0] level_next;
   logic               full_next;
   logic               afull_next;

   always_comb mem_we = wr_en & ~full & rst;

   assign wr_addr = wbin[ADDR_SIZE-1:0];

   always_comb begin
      wbin_next  = wbin + {{ADDR_SIZE{1'b0}}, mem_we};
      wgray_next = wbin_next ^ (wbin_next >> 1);
      // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it.
      rbin = '0;
      for (int i = 0; i <= ADDR_SIZE; i++) begin
         rbin[i] = ^(rptr_sync >> i);
      end
      level_next = wbin_next - rbin;
      full_next  = (wgray_next == {~rptr_sync[ADDR_SIZE:ADDR_SIZE-1], rptr_sync[ADDR_SIZE-2:0]});
      afull_next = (level_next >= AFULL_THRESH);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wbin        <= '0;
         wptr_gray   <= '0;
         full        <= 1'b0;
         almost_full <= 1'b0;
         overflow    <= 1'b0;
`ifdef FIFO_WR_LEVEL_EN
         wr_level    <= '0;
`endif
      end else begin
         wbin        <= wbin_next;
         wptr_gray   <= wgray_next;
         full        <= full_next;
         almost_full <= afull_next;
         // Set has priority over a simultaneous clear.
         overflow    <= (wr_en & full) | (overflow & ~ovf_clr);
`ifdef FIFO_WR_LEVEL_EN
         wr_level    <= level_next;
`endif
      end
   end

endmodule

// File: tb/tb_fifo_wr_ptr_ctrl.sv
// Bench for fifo_wr_ptr_ctrl: occupancy-counting model compared every negedge, plus directed literal checks.
module tb_fifo_wr_ptr_ctrl;

   localparam int AS    = 4;
   localparam int DEPTH = 16;
   localparam int PMOD  = 32;
   localparam int AF_TH = DEPTH - 2;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          wr_en = 1'b0;
   logic [AS:0]   rptr_sync = '0;
   logic          ovf_clr = 1'b0;
   logic          mem_we;
   logic [AS-1:0] wr_addr;
   logic [AS:0]   wptr_gray;
   logic          full;
   logic          almost_full;
   logic          overflow;
`ifdef FIFO_WR_LEVEL_EN
   logic [AS:0]   wr_level;
`endif

   int n_chk  = 0;
   int n_fail = 0;

   fifo_wr_ptr_ctrl #(.ADDR_SIZE(AS), .AFULL_MARGIN(2)) dut (
      .clk(clk), .rst(rst), .wr_en(wr_en), .rptr_sync(rptr_sync), .ovf_clr(ovf_clr),
      .mem_we(mem_we), .wr_addr(wr_addr), .wptr_gray(wptr_gray), .full(full),
      .almost_full(almost_full), .overflow(overflow)
`ifdef FIFO_WR_LEVEL_EN
      , .wr_level(wr_level)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
      end
   endtask

   function automatic int g2b(input int g);
      int b = 0;
      while (g != 0) begin
         b = b ^ g;
         g = g >> 1;
      end
      return b;
   endfunction

   function automatic int b2g(input int b);
      return b ^ (b >> 1);
   endfunction

   // Model: count of accepted writes and occupancy against the synchronized read count.
   int m_wcnt  = 0;
   int m_level = 0;
   bit m_full  = 0;
   bit m_afull = 0;
   bit m_ovf   = 0;

   function automatic int m_next_wcnt();
      return (m_wcnt + ((wr_en && !m_full) ? 1 : 0)) % PMOD;
   endfunction

   function automatic int m_next_level();
      return (m_next_wcnt() - g2b(int'(rptr_sync)) + PMOD) % PMOD;
   endfunction

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_wcnt  <= 0;
         m_level <= 0;
         m_full  <= 0;
         m_afull <= 0;
         m_ovf   <= 0;
      end else begin
         m_wcnt  <= m_next_wcnt();
         m_level <= m_next_level();
         m_full  <= (m_next_level() == DEPTH);
         m_afull <= (m_next_level() >= AF_TH);
         m_ovf   <= (wr_en && m_full) || (m_ovf && !ovf_clr);
      end
   end

   int prev_gray = 0;
   always @(negedge clk) begin
      chk("mdl_mem_we",  int'(mem_we),      int'(wr_en && !m_full && rst));
      chk("mdl_wr_addr", int'(wr_addr),     m_wcnt % DEPTH);
      chk("mdl_gray",    int'(wptr_gray),   m_wcnt ^ (m_wcnt >> 1));
      chk("mdl_full",    int'(full),        int'(m_full));
      chk("mdl_afull",   int'(almost_full), int'(m_afull));
      chk("mdl_ovf",     int'(overflow),    int'(m_ovf));
`ifdef FIFO_WR_LEVEL_EN
      chk("mdl_level",   int'(wr_level),    m_level);
`endif
      if (rst) begin
         chk("gray_onebit", ($countones(wptr_gray ^ prev_gray[AS:0]) <= 1) ? 1 : 0, 1);
         prev_gray = int'(wptr_gray);
      end else begin
         prev_gray = 0;
      end
   end

   task automatic setin(input bit we, input int rp, input bit clr);
      wr_en     = we;
      rptr_sync = rp[AS:0];
      ovf_clr   = clr;
      #1;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int w;
      // Reset held with write requested.
      setin(1, 0, 0);
      step(); step();
      chk("rst_mem_we", mem_we, 0);
      chk("rst_gray",   wptr_gray, 0);
      chk("rst_addr",   wr_addr, 0);
      chk("rst_full",   full, 0);
      chk("rst_afull",  almost_full, 0);
      chk("rst_ovf",    overflow, 0);
      rst = 1'b1;

      // Fill 16 entries with read pointer parked at 0.
      for (int i = 0; i < DEPTH; i++) begin
         setin(1, 0, 0);
         chk("fill_addr", wr_addr, i);
         chk("fill_we",   mem_we, 1);
         step();
         if (i == 12) chk("fill_afull_13", almost_full, 0);
         if (i == 13) chk("fill_afull_14", almost_full, 1);
         if (i == 14) chk("fill_full_15", full, 0);
      end
      chk("fill_full", full, 1);
      chk("fill_gray", wptr_gray, 5'b11000);

      // Overflow set, hold, clear, and set-beats-clear.
      setin(1, 0, 0);
      chk("ovf_we", mem_we, 0);
      step();
      chk("ovf_set",  overflow, 1);
      chk("ovf_gray", wptr_gray, 5'b11000);
      setin(0, 0, 0); step();
      chk("ovf_hold", overflow, 1);
      setin(0, 0, 1); step();
      chk("ovf_clr", overflow, 0);
      setin(1, 0, 1); step();
      chk("ovf_set_wins", overflow, 1);
      setin(0, 0, 1); step();
      chk("ovf_clr2", overflow, 0);

      // Drain release.
      setin(0, 5'b00001, 0); step();
      chk("drain_full",  full, 0);
      chk("drain_af15",  almost_full, 1);
      setin(0, 5'b00011, 0); step();
      chk("drain_af14",  almost_full, 1);
      setin(0, 5'b00010, 0); step();
      chk("drain_af13",  almost_full, 0);

      // Wrap: read count trails by 4.
      setin(0, b2g(12), 0); step();
      w = 16;
      for (int k = 0; k < 40; k++) begin
         int g0;
         setin(1, b2g((w + 1 - 4 + PMOD) % PMOD), 0);
         g0 = int'(wptr_gray);
         if (w == 31) chk("wrap_gray_pre", wptr_gray, 5'b10000);
         step();
         chk("wrap_flip1", $countones(wptr_gray ^ g0[AS:0]), 1);
         chk("wrap_nofull", full, 0);
         if (w == 31) chk("wrap_gray_zero", wptr_gray, 0);
`ifdef FIFO_WR_LEVEL_EN
         chk("wrap_level4", wr_level, 4);
`endif
         w = (w + 1) % PMOD;
      end

      // Nine writes then asynchronous reset between edges.
      for (int k = 0; k < 9; k++) begin
         setin(1, b2g(20), 0);
         step();
      end
      chk("mid_addr9", wr_addr, 1);
      #2;
      rst = 1'b0;
      #1;
      chk("arst_mem_we", mem_we, 0);
      chk("arst_gray",   wptr_gray, 0);
      chk("arst_addr",   wr_addr, 0);
      chk("arst_full",   full, 0);
      chk("arst_afull",  almost_full, 0);
      chk("arst_ovf",    overflow, 0);
      step();
      rst = 1'b1;
      setin(1, 0, 0);
      chk("resume_addr0", wr_addr, 0);
      chk("resume_we",    mem_we, 1);
      step();
      chk("resume_addr1", wr_addr, 1);
      chk("resume_gray",  wptr_gray, 5'b00001);
      setin(0, 0, 0);
      step(); step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/fifo_wr_ptr_ctrl.md
Name: fifo_wr_ptr_ctrl

Overview:
- Write-domain pointer and flag controller for the dual-clock asynchronous FIFO.
- Sits at the source end of the pointer crossing:
  - generates the registered Gray write pointer, which the read-domain synchronizer double-flops;
  - consumes the read pointer after it has been synchronized into the write domain.
- Drives the memory write enable and address.
- Produces full, almost_full and a sticky overflow flag.

Parameters:
- ADDR_SIZE, 4, memory address width; FIFO depth = 2**ADDR_SIZE; pointers are ADDR_SIZE+1 bits.
- AFULL_MARGIN, 2, almost_full asserts when free entries <= AFULL_MARGIN; legal range 1..2**ADDR_SIZE-1.

Ports:
- clk  in  1  write-domain clock.
- rst  in  1  asynchronous, active-low reset (asserted at 0).
- wr_en  in  1  write request from producer.
- rptr_sync  in  ADDR_SIZE+1  Gray read pointer, already double-flop synchronized into clk domain.
- ovf_clr  in  1  synchronous clear of overflow.
- mem_we  out  1  memory write strobe (combinational).
- wr_addr  out  ADDR_SIZE  memory write address.
- wptr_gray  out  ADDR_SIZE+1  registered Gray write pointer, to read-domain synchronizer.
- full  out  1  registered full flag.
- almost_full  out  1  registered almost-full flag.
- overflow  out  1  sticky: write attempted while full.

Behaviour:
- Reset (rst=0, async): wbin=0, wptr_gray=0, full=0, almost_full=0, overflow=0.
  - mem_we=0 while reset is asserted.
  - Reset release is synchronous to clk, handled externally.
- Accept: mem_we = wr_en & ~full & rst. wr_addr = wbin[ADDR_SIZE-1:0].
  - Data is written at the current address in the same cycle.
- Next pointers:
  - wbin_next = wbin + mem_we, modulo 2**(ADDR_SIZE+1).
  - wgray_next = wbin_next ^ (wbin_next >> 1).
- Registers update every clk:
  - wbin <= wbin_next;
  - wptr_gray <= wgray_next, registered only, never combinational to the output.
- wptr_gray changes by at most one bit per cycle, including the wrap 2**(ADDR_SIZE+1)-1 -> 0.
- Full:
  - full <= (wgray_next == {~rptr_sync[ADDR_SIZE:ADDR_SIZE-1], rptr_sync[ADDR_SIZE-2:0]}).
  - Full asserts on the edge that accepts the last free slot: no write-through-full latency.
  - Full deasserts one clk after rptr_sync advances. This is pessimistic and safe.
- Level:
  - rbin = Gray-to-binary of rptr_sync (XOR prefix from MSB).
  - level_next = (wbin_next - rbin), computed in ADDR_SIZE+1 bits; range 0..2**ADDR_SIZE.
- almost_full <= (level_next >= 2**ADDR_SIZE - AFULL_MARGIN). It is set whenever full is set.
- Overflow:
  - set when wr_en & full;
  - cleared by ovf_clr;
  - if set and clear occur in the same cycle, set wins;
  - pointer and memory are unaffected by a rejected write.
- Simultaneous write and rptr_sync advance while full=1: the write is rejected, because full is the registered value. Full clears on the next edge.
- Mid-operation reset: all state returns to reset values immediately. Any in-flight write is dropped.
- rptr_sync is assumed Gray-coherent because it comes from a synchronizer. No further filtering is done on it.

Optional Feature:
- Macro FIFO_WR_LEVEL_EN.
- Defined:
  - adds output port wr_level [ADDR_SIZE:0];
  - wr_level <= level_next, registered, reset 0;
  - value equals occupancy as seen from the write domain, 0..2**ADDR_SIZE.
- Undefined:
  - port absent;
  - level_next is used internally only for almost_full.
  - No other behaviour change.

Test Plan (ADDR_SIZE=4, AFULL_MARGIN=2, depth 16):
- Reset:
  - Stimulus: hold rst=0 with wr_en=1.
  - Required: mem_we=0, wptr_gray=5'b00000, wr_addr=0, full=0, almost_full=0, overflow=0.
- Fill to full:
  - Stimulus: rptr_sync=0, 16 consecutive wr_en cycles.
  - Required:
    - wr_addr steps 0..15;
    - almost_full=1 after the 14th accepted write;
    - full=1 after the 16th accepted write;
    - wptr_gray=5'b11000.
- Overflow:
  - Stimulus: 17th wr_en while full.
  - Required:
    - mem_we=0; wptr_gray stays 5'b11000; overflow=1;
    - overflow stays 1 until ovf_clr pulse, then 0;
    - ovf_clr together with wr_en&full -> overflow stays 1.
- Drain release:
  - Stimulus: rptr_sync 00000 -> 00001 (read ptr 1), wr_en=0.
  - Required: full=0 next edge; almost_full stays 1 (level 15).
  - Stimulus: then rptr_sync=00011 (read ptr 2), then 00010 (read ptr 3).
  - Required: almost_full stays 1 at level 14; clears at level 13.
- Wrap:
  - Stimulus: 40 writes with rptr_sync trailing by 4 entries.
  - Required:
    - every accepted write flips exactly one wptr_gray bit;
    - the 10000 -> 00000 transition occurs at binary 31 -> 0;
    - full never asserts;
    - with FIFO_WR_LEVEL_EN, wr_level=4 in steady state.
- Async reset mid-fill:
  - Stimulus: after 9 writes, drive rst=0 between clk edges.
  - Required: outputs return to reset values before the next edge; writing resumes at wr_addr=0 after release.
